// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchroniser, glitch filter, frame FSM with timeout, and show-ahead scancode FIFO.
// Optional prefix decoding (0xE0/0xF0 folded into flags) is enabled by defining PS2_RX_PREFIX_DECODE_EN.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                            CLOCK_50,
   input  logic                            rst,
   input  logic                            PS2_CLK,
   input  logic                            PS2_DAT,
   input  logic                            rd_en,
   output logic [9:0]                      rd_data,
   output logic                            empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
   output logic                            parity_err,
   output logic                            frame_err,
   output logic                            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic                  ps2c_p0, ps2c_p1;
   logic                  ps2d_p0, ps2d_p1;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt_state;
   logic                  filt_prev;
   logic                  bit_evt;

   frame_state_t          state, state_nx;
   logic [2:0]            bit_cnt;
   logic [TW-1:0]         to_cnt;
   logic [7:0]            shift_reg;
   logic                  par_bit;
   logic                  accept, perr, ferr, tmo;
   logic                  push_req;

   logic                  vld_p2;
   logic [9:0]            byte_p2;
   logic [9:0]            mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  full, do_push, do_pop;

`ifdef PS2_RX_PREFIX_DECODE_EN
   logic                  pend_ext, pend_rel;
   logic                  is_e0, is_f0;
`endif

   // ---- synchroniser and glitch filter
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         ps2c_p0    <= 1'b1;
         ps2c_p1    <= 1'b1;
         ps2d_p0    <= 1'b1;
         ps2d_p1    <= 1'b1;
         filt_sr    <= '1;
         filt_state <= 1'b1;
         filt_prev  <= 1'b1;
      end else begin
         ps2c_p0    <= PS2_CLK;
         ps2c_p1    <= ps2c_p0;
         ps2d_p0    <= PS2_DAT;
         ps2d_p1    <= ps2d_p0;
         filt_sr    <= {filt_sr[FILTER_LEN-2:0], ps2c_p1};
         filt_prev  <= filt_state;
         if (&filt_sr)
            filt_state <= 1'b1;
         else if (~|filt_sr)
            filt_state <= 1'b0;
      end
   end

   assign bit_evt = filt_prev & ~filt_state;

   // ---- frame FSM
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      perr     = 1'b0;
      ferr     = 1'b0;
      tmo      = 1'b0;
      if (state != IDLE && !bit_evt && to_cnt == TO_LAST) begin
         state_nx = IDLE;
         ferr     = 1'b1;
         tmo      = 1'b1;
      end else if (bit_evt) begin
         case (state)
            IDLE:   if (!ps2d_p1) state_nx = DATA;
            DATA:   if (bit_cnt == 3'd7) state_nx = PARITY;
            PARITY: state_nx = STOP;
            STOP: begin
               state_nx = IDLE;
               if (!ps2d_p1)
                  ferr = 1'b1;
               else if (odd_parity_ok(shift_reg, par_bit))
                  accept = 1'b1;
               else
                  perr = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

`ifdef PS2_RX_PREFIX_DECODE_EN
   assign is_e0    = (shift_reg == 8'hE0);
   assign is_f0    = (shift_reg == 8'hF0);
   assign push_req = accept & ~is_e0 & ~is_f0;
`else
   assign push_req = accept;
`endif

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         to_cnt  <= '0;
      end else begin
         if (state == IDLE)
            bit_cnt <= '0;
         else if (bit_evt && state == DATA)
            bit_cnt <= bit_cnt + 3'd1;
         if (state == IDLE || bit_evt || tmo)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TW'(1);
      end
   end

`ifdef PS2_RX_PREFIX_DECODE_EN
   // Pending prefixes survive until a real byte consumes them or the frame is bad.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         pend_ext <= 1'b0;
         pend_rel <= 1'b0;
      end else if (perr || ferr) begin
         pend_ext <= 1'b0;
         pend_rel <= 1'b0;
      end else if (accept) begin
         if (is_e0)
            pend_ext <= 1'b1;
         else if (is_f0)
            pend_rel <= 1'b1;
         else begin
            pend_ext <= 1'b0;
            pend_rel <= 1'b0;
         end
      end
   end
`endif

   // ---- frame datapath and push stage
   always_ff @(posedge CLOCK_50) begin
      if (bit_evt && state == DATA)
         shift_reg <= {ps2d_p1, shift_reg[7:1]};
      if (bit_evt && state == PARITY)
         par_bit <= ps2d_p1;
`ifdef PS2_RX_PREFIX_DECODE_EN
      byte_p2 <= {pend_rel, pend_ext, shift_reg};
`else
      byte_p2 <= {2'b00, shift_reg};
`endif
      if (do_push)
         mem[wr_ptr] <= byte_p2;
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         vld_p2     <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         vld_p2     <= push_req;
         parity_err <= perr;
         frame_err  <= ferr;
      end
   end

   // ---- FIFO
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = rd_en & ~empty;
   assign do_push = vld_p2 & (~full | do_pop);
   assign rd_data = empty ? 10'd0 : mem[rd_ptr];

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count    <= count + CW'(do_push) - CW'(do_pop);
         overflow <= vld_p2 & full & ~do_pop;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: stimulus queues expected bytes/pulses, a monitor compares them.
module tb_ps2_rx_fifo;

   localparam int FILTER_LEN     = 8;
   localparam int FIFO_DEPTH     = 16;
   localparam int TIMEOUT_CYCLES = 50000;
   localparam int HALF           = 16;
   // Cycles from driving PS2_CLK low (just after an edge) to the cycle in which the byte is pushed:
   // 2 sync flops + FILTER_LEN filter shifts + filtered-state register + event-to-push register.
   localparam int EVT_LAT        = FILTER_LEN + 4;
   localparam int CW             = $clog2(FIFO_DEPTH + 1);

   localparam int K_PAR = 1;
   localparam int K_FRM = 2;
   localparam int K_OVF = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          PS2_CLK = 1'b1;
   logic          PS2_DAT = 1'b1;
   logic          rd_en = 1'b0;
   logic [9:0]    rd_data;
   logic          empty;
   logic [CW-1:0] count;
   logic          parity_err, frame_err, overflow;

   int n_total = 0;
   int n_pass  = 0;
   logic [9:0] data_q[$];
   int         pulse_q[$];

   ps2_rx_fifo #(
      .FILTER_LEN(FILTER_LEN),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .CLOCK_50(clk),
      .rst(rst),
      .PS2_CLK(PS2_CLK),
      .PS2_DAT(PS2_DAT),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .empty(empty),
      .count(count),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .overflow(overflow)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      n_total++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   // Monitor: every pulse and every accepted pop is matched against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (parity_err) begin
            if (pulse_q.size() == 0) fail_now("unexpected_parity_err", 32'(K_PAR));
            else check("pulse_kind", 32'(K_PAR), 32'(pulse_q.pop_front()));
         end
         if (frame_err) begin
            if (pulse_q.size() == 0) fail_now("unexpected_frame_err", 32'(K_FRM));
            else check("pulse_kind", 32'(K_FRM), 32'(pulse_q.pop_front()));
         end
         if (overflow) begin
            if (pulse_q.size() == 0) fail_now("unexpected_overflow", 32'(K_OVF));
            else check("pulse_kind", 32'(K_OVF), 32'(pulse_q.pop_front()));
         end
         if (rd_en && !empty) begin
            if (data_q.size() == 0) fail_now("unexpected_pop", 32'(rd_data));
            else check("rd_data", 32'(rd_data), 32'(data_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      PS2_DAT = b;
      tick(HALF);
      PS2_CLK = 1'b0;
      tick(HALF);
      PS2_CLK = 1'b1;
   endtask

   // Sends start..parity, then drops the clock for the stop bit and returns in the push cycle.
   task automatic frame_head(input logic [7:0] d, input logic par, input logic stp);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      PS2_DAT = stp;
      tick(HALF);
      PS2_CLK = 1'b0;
      tick(EVT_LAT);
   endtask

   task automatic frame_tail(input int n);
      tick(n);
      PS2_CLK = 1'b1;
   endtask

   task automatic frame(input logic [7:0] d, input logic par, input logic stp);
      frame_head(d, par, stp);
      frame_tail(HALF - EVT_LAT);
      tick(2);
   endtask

   task automatic good_frame(input logic [7:0] d);
      frame(d, ~^d, 1'b1);
   endtask

   task automatic pop_n(input int n);
      rd_en = 1'b1;
      tick(n);
      rd_en = 1'b0;
      tick(1);
   endtask

   initial begin
      // Reset state
      tick(4);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_pulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
      rst = 1'b0;
      tick(4);

      // Valid 0x1C, parity 0: empty must fall exactly at the push edge
      data_q.push_back(10'h01C);
      frame_head(8'h1C, 1'b0, 1'b1);
      check("lat_empty_before", 32'(empty), 32'd1);
      tick(1);
      check("lat_empty_after", 32'(empty), 32'd0);
      check("lat_count", 32'(count), 32'd1);
      check("lat_rd_data", 32'(rd_data), 32'h01C);
      frame_tail(HALF - EVT_LAT - 1);
      pop_n(1);
      check("pop_empty", 32'(empty), 32'd1);

      // Parity error and stop-bit error
      pulse_q.push_back(K_PAR);
      frame(8'h1C, 1'b1, 1'b1);
      check("perr_count", 32'(count), 32'd0);
      pulse_q.push_back(K_FRM);
      frame(8'h1C, 1'b0, 1'b0);
      check("ferr_count", 32'(count), 32'd0);

      // Timeout on a partial frame, then a clean frame
      pulse_q.push_back(K_FRM);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      tick(TIMEOUT_CYCLES + 100);
      check("tmo_queue_drained", 32'(pulse_q.size()), 32'd0);
      data_q.push_back(10'h032);
      good_frame(8'h32);
      check("tmo_next_count", 32'(count), 32'd1);
      pop_n(1);

      // Fill to full, overflow on the 17th, then push+pop at full
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         data_q.push_back({2'b00, 8'h40 + 8'(i)});
         good_frame(8'h40 + 8'(i));
      end
      check("full_count", 32'(count), 32'(FIFO_DEPTH));
      pulse_q.push_back(K_OVF);
      good_frame(8'h50);
      check("ovf_count", 32'(count), 32'(FIFO_DEPTH));
      data_q.push_back(10'h051);
      frame_head(8'h51, ~^8'h51, 1'b1);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      frame_tail(HALF - EVT_LAT - 1);
      tick(2);
      check("pushpop_count", 32'(count), 32'(FIFO_DEPTH));
      pop_n(FIFO_DEPTH);
      check("drain_empty", 32'(empty), 32'd1);
      pop_n(2);
      check("pop_when_empty_count", 32'(count), 32'd0);

      // Prefix bytes
`ifdef PS2_RX_PREFIX_DECODE_EN
      data_q.push_back(10'h375);
`else
      data_q.push_back(10'h0E0);
      data_q.push_back(10'h0F0);
      data_q.push_back(10'h075);
`endif
      good_frame(8'hE0);
      good_frame(8'hF0);
      good_frame(8'h75);
`ifdef PS2_RX_PREFIX_DECODE_EN
      check("prefix_count", 32'(count), 32'd1);
      pop_n(1);
`else
      check("prefix_count", 32'(count), 32'd3);
      pop_n(3);
`endif

      // 3-cycle low glitch with data low must not start a frame
      PS2_DAT = 1'b0;
      PS2_CLK = 1'b0;
      tick(3);
      PS2_CLK = 1'b1;
      tick(20);
      data_q.push_back(10'h05A);
      good_frame(8'h5A);
      check("glitch_count", 32'(count), 32'd1);
      pop_n(1);

      // Reset mid-frame with an entry held in the FIFO
      good_frame(8'h11);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b1;
      #1;
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_rd_data", 32'(rd_data), 32'd0);
      tick(3);
      rst = 1'b0;
      tick(5);
      data_q.push_back(10'h029);
      good_frame(8'h29);
      check("postrst_count", 32'(count), 32'd1);
      pop_n(1);

      tick(10);
      check("pulse_q_left", 32'(pulse_q.size()), 32'd0);
      check("data_q_left", 32'(data_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
